// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/issue sequencer: owns PC and IR, fetches over a req/ack port,
// then walks each instruction through decode, execute, memory, writeback and PC update.
module instr_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic [ADDR_W-1:0]  StartPC,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [5:0]         Op,
    output logic [INSTR_W-1:0] Instr,
    input  logic               IncPCJTA,
    input  logic [1:0]         JmpType,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               RegWrite,
    output logic               ExecGo,
    input  logic               ExecDone,
    input  logic               FlagEq,
    input  logic               FlagGt,
    input  logic               FlagLs,
    output logic               DMemReq,
    input  logic               DMemAck,
    output logic               WbEn,
    output logic               Busy,
    output logic               Halted,
    output logic [ADDR_W-1:0]  PC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_MLD   = 6'b000000;
    localparam logic [5:0] OP_MSTR  = 6'b000001;
    localparam logic [5:0] OP_MCMP  = 6'b011000;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [INSTR_W-1:0]  ir_reg, ir_next;
    logic [2:0]          flags_reg, flags_next;   // {eq, gt, ls}
    logic                exec_first_reg, exec_first_next;

    logic [5:0] op;
    logic       is_jump;
    logic       is_mem;
    logic       is_matrix_arith;
    logic       is_exec;
    logic       jump_taken;
    logic       mem_active;

    // The jump/no-jump choice comes from the opcode group and the latched flags.
    logic unused_decoder;
    assign unused_decoder = IncPCJTA;

    assign op              = ir_reg[INSTR_W-1 -: 6];
    assign is_jump         = (op[5:2] == 4'b0111);
    assign is_mem          = (op == OP_MLD) || (op == OP_MSTR);
    assign is_matrix_arith = (op == 6'b001000) || (op == 6'b001001) ||
                             (op == 6'b001100) || (op == 6'b001101);
    assign is_exec         = is_matrix_arith || (op == OP_MCMP) || (op == 6'b100100);
    assign mem_active      = MemRead | MemWrite;

    always_comb begin
        jump_taken = 1'b0;
        case (JmpType)
            2'b00: jump_taken = 1'b1;
            2'b01: jump_taken = flags_reg[2];
            2'b10: jump_taken = flags_reg[1];
            2'b11: jump_taken = flags_reg[0];
            default: jump_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            pc_reg         <= '0;
            ir_reg         <= '0;
            flags_reg      <= '0;
            exec_first_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ir_reg         <= ir_next;
            flags_reg      <= flags_next;
            exec_first_reg <= exec_first_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ir_next         = ir_reg;
        flags_next      = flags_reg;
        exec_first_next = 1'b0;
        IMemReq         = 1'b0;
        ExecGo          = 1'b0;
        DMemReq         = 1'b0;
        WbEn            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    pc_next    = StartPC;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    ir_next    = IMemData;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_next = S_HALT;
                end else if (is_jump) begin
                    state_next = S_PCUPD;
                end else if (is_mem) begin
                    state_next = S_MEM;
                end else if (is_exec) begin
                    state_next      = S_EXEC;
                    exec_first_next = 1'b1;
                end else begin
                    state_next = S_PCUPD;
                end
            end
            S_EXEC: begin
                ExecGo = exec_first_reg;
                // A done seen during the launch cycle belongs to nothing we started.
                if (!exec_first_reg && ExecDone) begin
                    if (op == OP_MCMP) begin
                        flags_next = {FlagEq, FlagGt, FlagLs};
                    end
                    state_next = (RegWrite || is_matrix_arith) ? S_WB : S_PCUPD;
                end
            end
            S_MEM: begin
                DMemReq = mem_active;
                if (!mem_active || DMemAck) begin
                    state_next = MemRead ? S_WB : S_PCUPD;
                end
            end
            S_WB: begin
                WbEn       = 1'b1;
                state_next = S_PCUPD;
            end
            S_PCUPD: begin
                if (is_jump && jump_taken) begin
                    pc_next = ir_reg[ADDR_W-1:0];
                end else begin
                    pc_next = pc_reg + PC_ONE;
                end
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign IMemAddr = pc_reg;
    assign PC       = pc_reg;
    assign Op       = op;
    assign Instr    = ir_reg;
    assign Busy     = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign Halted   = (state_reg == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: cycle-exact stimulus with a tiny opcode decoder model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] StartPC = '0;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = '0;
    logic [5:0]  Op;
    logic [31:0] Instr;
    logic        IncPCJTA;
    logic [1:0]  JmpType;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        ExecGo;
    logic        ExecDone = 1'b0;
    logic        FlagEq = 1'b0;
    logic        FlagGt = 1'b0;
    logic        FlagLs = 1'b0;
    logic        DMemReq;
    logic        DMemAck = 1'b0;
    logic        WbEn;
    logic        Busy;
    logic        Halted;
    logic [15:0] PC;

    int checks = 0;
    int passes = 0;

    instr_sequencer #(.ADDR_W(16), .INSTR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .StartPC(StartPC),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
        .Op(Op), .Instr(Instr), .IncPCJTA(IncPCJTA), .JmpType(JmpType),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ExecGo(ExecGo), .ExecDone(ExecDone), .FlagEq(FlagEq), .FlagGt(FlagGt),
        .FlagLs(FlagLs), .DMemReq(DMemReq), .DMemAck(DMemAck), .WbEn(WbEn),
        .Busy(Busy), .Halted(Halted), .PC(PC)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational opcode decoder.
    always_comb begin
        IncPCJTA = (Op[5:2] == 4'b0111);
        JmpType  = (Op[5:2] == 4'b0111) ? Op[1:0] : 2'b00;
        MemRead  = (Op == 6'b000000);
        MemWrite = (Op == 6'b000001);
        RegWrite = (Op == 6'b100100);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_at(input logic [15:0] addr);
        StartPC = addr;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] word);
        IMemData = word;
        IMemAck  = 1'b1;
        tick();
        IMemAck  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({IMemReq, ExecGo, DMemReq, WbEn, Busy, Halted} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000", {IMemReq, ExecGo, DMemReq, WbEn, Busy, Halted});
            else passes++;
        checks++; if ({PC, Op, Instr} !== 54'd0)
            $display("FAIL reset_regs pc=%h op=%b instr=%h want zeros", PC, Op, Instr); else passes++;
        start_at(16'h0033);
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0033)
            $display("FAIL fetch_req got req=%b addr=%h want 1 0033", IMemReq, IMemAddr); else passes++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (IMemReq !== 1'b0 || PC !== 16'h0000 || Busy !== 1'b0)
            $display("FAIL reset_midfetch got req=%b pc=%h busy=%b want 0 0000 0", IMemReq, PC, Busy); else passes++;
        deliver(32'h2000_0000);
        checks++; if (Busy !== 1'b0 || Instr !== 32'h0 || PC !== 16'h0 || IMemReq !== 1'b0)
            $display("FAIL late_ack got busy=%b instr=%h pc=%h want 0 0 0", Busy, Instr, PC); else passes++;
    endtask

    task automatic test_madd();
        int go_count;
        do_reset();
        start_at(16'h0010);
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0010)
            $display("FAIL madd_fetch got req=%b addr=%h want 1 0010", IMemReq, IMemAddr); else passes++;
        deliver(32'h2000_0000);
        checks++; if (Op !== 6'b001000 || Instr !== 32'h2000_0000)
            $display("FAIL madd_ir got op=%b instr=%h want 001000 20000000", Op, Instr); else passes++;
        go_count = 0;
        tick();
        checks++; if (ExecGo !== 1'b1)
            $display("FAIL madd_go got %b want 1", ExecGo); else passes++;
        if (ExecGo) go_count++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (ExecGo) go_count++;
        end
        ExecDone = 1'b1;
        tick();
        ExecDone = 1'b0;
        checks++; if (WbEn !== 1'b1 || go_count !== 1)
            $display("FAIL madd_wb got wb=%b go_count=%0d want 1 1", WbEn, go_count); else passes++;
        tick();
        checks++; if (WbEn !== 1'b0)
            $display("FAIL madd_wb_len got %b want 0", WbEn); else passes++;
        tick();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0011)
            $display("FAIL madd_next got req=%b addr=%h want 1 0011", IMemReq, IMemAddr); else passes++;
    endtask

    // Continues from test_madd: FETCH at 0x0011.
    task automatic test_mcmp_jump();
        deliver(32'h6000_0000);
        tick();
        checks++; if (ExecGo !== 1'b1)
            $display("FAIL mcmp_go got %b want 1", ExecGo); else passes++;
        ExecDone = 1'b1;
        FlagEq   = 1'b0;
        tick();
        checks++; if (ExecGo !== 1'b0 || WbEn !== 1'b0 || IMemReq !== 1'b0)
            $display("FAIL mcmp_entry_done go=%b wb=%b req=%b want 0 0 0", ExecGo, WbEn, IMemReq); else passes++;
        FlagEq = 1'b1;
        tick();
        ExecDone = 1'b0;
        FlagEq   = 1'b0;
        checks++; if (WbEn !== 1'b0)
            $display("FAIL mcmp_no_wb got %b want 0", WbEn); else passes++;
        tick();
        checks++; if (IMemAddr !== 16'h0012)
            $display("FAIL mcmp_next got %h want 0012", IMemAddr); else passes++;
        deliver(32'h7400_0040);
        tick();
        tick();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0040 || PC !== 16'h0040)
            $display("FAIL jeq_taken got req=%b addr=%h pc=%h want 1 0040 0040", IMemReq, IMemAddr, PC); else passes++;
        deliver(32'h6000_0000);
        tick();
        tick();
        ExecDone = 1'b1;
        FlagGt   = 1'b1;
        tick();
        ExecDone = 1'b0;
        FlagGt   = 1'b0;
        tick();
        checks++; if (IMemAddr !== 16'h0041)
            $display("FAIL mcmp2_next got %h want 0041", IMemAddr); else passes++;
        deliver(32'h7400_0040);
        tick();
        tick();
        checks++; if (IMemAddr !== 16'h0042)
            $display("FAIL jeq_not_taken got %h want 0042", IMemAddr); else passes++;
        deliver(32'h7800_0080);
        tick();
        tick();
        checks++; if (IMemAddr !== 16'h0080)
            $display("FAIL jgt_taken got %h want 0080", IMemAddr); else passes++;
    endtask

    task automatic test_mem();
        int req_count;
        int wb_seen;
        do_reset();
        start_at(16'h0100);
        deliver(32'h0000_0000);
        tick();
        req_count = 0;
        for (int i = 0; i < 4; i++) begin
            if (DMemReq) req_count++;
            if (i == 3) DMemAck = 1'b1;
            tick();
        end
        DMemAck = 1'b0;
        checks++; if (req_count !== 4 || WbEn !== 1'b1 || DMemReq !== 1'b0)
            $display("FAIL mld got req_cycles=%0d wb=%b req=%b want 4 1 0", req_count, WbEn, DMemReq); else passes++;
        tick();
        tick();
        checks++; if (IMemAddr !== 16'h0101)
            $display("FAIL mld_next got %h want 0101", IMemAddr); else passes++;
        deliver(32'h0400_0000);
        tick();
        req_count = 0;
        wb_seen   = 0;
        for (int i = 0; i < 3; i++) begin
            if (DMemReq) req_count++;
            if (WbEn) wb_seen++;
            if (i == 2) DMemAck = 1'b1;
            tick();
        end
        DMemAck = 1'b0;
        if (WbEn) wb_seen++;
        tick();
        checks++; if (req_count !== 3 || wb_seen !== 0 || IMemAddr !== 16'h0102)
            $display("FAIL mstr got req_cycles=%0d wb=%0d addr=%h want 3 0 0102", req_count, wb_seen, IMemAddr); else passes++;
    endtask

    task automatic test_wrap_halt();
        do_reset();
        start_at(16'hFFFF);
        checks++; if (IMemAddr !== 16'hFFFF)
            $display("FAIL wrap_fetch got %h want ffff", IMemAddr); else passes++;
        deliver(32'h4000_0000);
        tick();
        tick();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000)
            $display("FAIL wrap got req=%b addr=%h want 1 0000", IMemReq, IMemAddr); else passes++;
        deliver(32'hFC00_0000);
        tick();
        checks++; if (Halted !== 1'b1 || Busy !== 1'b0)
            $display("FAIL halt got halted=%b busy=%b want 1 0", Halted, Busy); else passes++;
        start_at(16'h0005);
        tick();
        checks++; if (IMemReq !== 1'b0 || Halted !== 1'b1 || PC !== 16'h0000)
            $display("FAIL halt_start got req=%b halted=%b pc=%h want 0 1 0000", IMemReq, Halted, PC); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] word;
        do_reset();
        start_at(16'h0020);
        IMemAck = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0020 + 16'(k))
                $display("FAIL b2b_fetch%0d got req=%b addr=%h want 1 %h", k, IMemReq, IMemAddr, 16'h0020 + 16'(k));
                else passes++;
            word = 32'h4000_0100 + 32'(k);
            IMemData = word;
            tick();
            checks++; if (Instr !== word)
                $display("FAIL b2b_load%0d got %h want %h", k, Instr, word); else passes++;
            IMemData = 32'h4000_0AAA;
            tick();
            checks++; if (Instr !== word)
                $display("FAIL b2b_hold%0d got %h want %h", k, Instr, word); else passes++;
            tick();
        end
        IMemAck = 1'b0;
        checks++; if (IMemAddr !== 16'h0023)
            $display("FAIL b2b_final got %h want 0023", IMemAddr); else passes++;
    endtask

    initial begin
        test_reset();
        test_madd();
        test_mcmp_jump();
        test_mem();
        test_wrap_halt();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/issue sequencer for the matrix core.
- Owns PC and IR, fetches 32-bit instruction words over a req/ack memory port and presents Op[5:0] to the combinational opcode decoder.
- Consumes the decoder's control outputs and steps the datapath through decode, execute, memory and writeback.
- Resolves jumps, conditional on MCMP flags, and updates PC.

Parameters:
- ADDR_W, 16: PC / memory address width.
- INSTR_W, 32: instruction word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- Start  in  1  one-cycle pulse; leaves IDLE and begins fetch at StartPC.
- StartPC  in  ADDR_W  initial PC, sampled when Start is accepted.
- IMemReq  out  1  instruction fetch request.
- IMemAddr  out  ADDR_W  fetch address (= PC).
- IMemAck  in  1  fetch data valid.
- IMemData  in  INSTR_W  fetched word.
- Op  out  6  IR[31:26], to decoder.
- Instr  out  INSTR_W  full IR, to datapath field extractors.
- IncPCJTA  in  1  decoder output.
- JmpType  in  2  decoder output.
- MemRead  in  1  decoder output.
- MemWrite  in  1  decoder output.
- RegWrite  in  1  decoder output.
- ExecGo  out  1  one-cycle pulse starting the AU/ZERO/Logic unit.
- ExecDone  in  1  unit finished; may arrive the same cycle as ExecGo+1 or later.
- FlagEq  in  1  Logic unit compare result.
- FlagGt  in  1  Logic unit compare result.
- FlagLs  in  1  Logic unit compare result.
- DMemReq  out  1  data memory request (MLD/MSTR).
- DMemAck  in  1  data memory done.
- WbEn  out  1  one-cycle register/matrix writeback strobe.
- Busy  out  1  high in every state except IDLE and HALT.
- Halted  out  1  high in HALT.
- PC  out  ADDR_W  current PC.

Behaviour:
- Reset, synchronous on rst_n=0 at posedge clk: state=IDLE, PC=0, IR=0, flags register=0. All outputs are 0; Op=0, Instr=0.
- Reset mid-fetch or mid-memory abandons the transaction: request drops the next edge, and a late Ack is ignored in IDLE.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT.
- IDLE:
  - Start=1 -> PC<=StartPC, go FETCH.
  - Start ignored in every other state.
- FETCH:
  - IMemReq=1, IMemAddr=PC, held until IMemAck.
  - On Ack: IR<=IMemData, go DECODE.
  - Ack is sampled only while Req=1.
- DECODE: exactly one cycle for decoder settling. Next state:
  - Op==6'b111111 -> HALT.
  - Op[5:2]==4'b0111 (jump group) -> PCUPD.
  - Op==6'b000000 or 6'b000001 -> MEM.
  - Op in {001000, 001001, 001100, 001101, 011000, 100100} -> EXEC.
  - All other opcodes (integer ops, ICMP, undefined) -> NOP: PCUPD with PC+1.
- EXEC:
  - ExecGo pulses for exactly the first EXEC cycle.
  - Wait for ExecDone; ExecDone in the entry cycle is ignored.
  - If Op==011000 (MCMP), latch {FlagEq, FlagGt, FlagLs} on ExecDone.
  - Then WB if RegWrite is high or Op is one of the four matrix arithmetic opcodes, else PCUPD.
- MEM:
  - DMemReq=1 while MemRead|MemWrite, held until DMemAck.
  - Then WB if MemRead, else PCUPD.
- WB: WbEn=1 for one cycle; go PCUPD.
- PCUPD: one cycle, then FETCH.
  - Jump taken when JmpType=00, or 01 & EQ, or 10 & GT, or 11 & LS, using the latched flags.
  - Taken: PC<=IR[ADDR_W-1:0].
  - Otherwise: PC<=PC+1, modulo 2^ADDR_W; 0xFFFF wraps to 0x0000.
- HALT:
  - Halted=1, Busy=0.
  - Leaves HALT only via reset. Start is ignored.
- Op and Instr reflect the IR continuously. IR changes only on a FETCH ack.
- Latency per instruction:
  - NOP: fetch + 2 cycles.
  - EXEC: fetch + 1 + exec + (WB) + 1.
- The latched flags persist across instructions until the next MCMP or reset.

Test Plan:
- Reset with rst_n=0 during FETCH while IMemReq=1 -> next cycle IMemReq=0, PC=0, Busy=0. A late IMemAck causes no state change.
- Start with StartPC=0x0010; IMemData=0x20000000 (MADD); ExecDone 3 cycles after ExecGo -> ExecGo pulses once, WbEn one cycle, then a fetch at 0x0011.
- MCMP with FlagEq=1 on ExecDone, then JEQ with IR[15:0]=0x0040 -> next IMemAddr=0x0040. Repeat with FlagEq=0 -> 0x0042, i.e. PC+1 after the JEQ at 0x0041.
- MLD (op 000000) with DMemAck delayed 4 cycles -> DMemReq held 4 cycles, then WbEn. MSTR -> DMemReq held until Ack, WbEn never asserted.
- PC=0xFFFF executing an IADD (NOP) -> next fetch address 0x0000. Op=6'b111111 -> Halted=1, and a later Start produces no IMemReq.
- IMemAck held high continuously across back-to-back NOPs -> exactly one IR load per FETCH entry, PC increments by 1 per instruction.
